// File: rtl/lut_pkg.sv
// Shared types and LookupTable contents for the immediate LUT arbiter.
//   lut_idx_t   : 3-bit LUT index
//   lut_data_t  : 8-bit LUT value (two's complement immediates)
//   arb_state_t : arbiter response-slot state
package lut_pkg;

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 8;

   typedef logic [IDX_W-1:0]  lut_idx_t;
   typedef logic [DATA_W-1:0] lut_data_t;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_t;

   // Immediate table: 100, 10, 5, 1, 0, -1, -30, -5
   localparam lut_data_t LUT_VAL0 = 8'h64;
   localparam lut_data_t LUT_VAL1 = 8'h0A;
   localparam lut_data_t LUT_VAL2 = 8'h05;
   localparam lut_data_t LUT_VAL3 = 8'h01;
   localparam lut_data_t LUT_VAL4 = 8'h00;
   localparam lut_data_t LUT_VAL5 = 8'hFF;
   localparam lut_data_t LUT_VAL6 = 8'hE2;
   localparam lut_data_t LUT_VAL7 = 8'hFB;

endpackage

// File: rtl/LookupTable.sv
// Combinational 8-entry immediate table; the arbiter registers the result.
//   instruction : in  3  table index
//   out         : out 8  table value for instruction
module LookupTable
   import lut_pkg::*;
(
   input  logic [2:0] instruction,
   output logic [7:0] out
);

   always_comb begin
      out = LUT_VAL0;
      case (instruction)
         3'd0: out = LUT_VAL0;
         3'd1: out = LUT_VAL1;
         3'd2: out = LUT_VAL2;
         3'd3: out = LUT_VAL3;
         3'd4: out = LUT_VAL4;
         3'd5: out = LUT_VAL5;
         3'd6: out = LUT_VAL6;
         3'd7: out = LUT_VAL7;
         default: out = LUT_VAL0;
      endcase
   end

endmodule

// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one LookupTable between decode (req0) and the
// branch-offset unit (req1), with a one-deep registered response slot.
//   clk, reset_n                 : clock, async active-low reset
//   req*_valid/idx, req*_ready   : request handshake (ready is combinational)
//   rsp*_valid/data, rsp*_ready  : response handshake (registered)
//   busy                         : response slot occupied
//   grant_cnt0/1                 : saturating per-requester grant counters
module lut_arbiter
   import lut_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned RESET_PTR = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   input  logic [2:0]       req0_idx,
   output logic             req0_ready,
   output logic             rsp0_valid,
   output logic [7:0]       rsp0_data,
   input  logic             rsp0_ready,
   input  logic             req1_valid,
   input  logic [2:0]       req1_idx,
   output logic             req1_ready,
   output logic             rsp1_valid,
   output logic [7:0]       rsp1_data,
   input  logic             rsp1_ready,
   output logic             busy,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   arb_state_t       state_q, state_d;
   logic             owner_q, owner_d;   // 0: req0 owns the slot, 1: req1
   logic             ptr_q,   ptr_d;     // requester favoured on contention
   lut_data_t        rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic      rsp_hs;
   logic      slot_free;
   logic      grant0, grant1;
   lut_idx_t  win_idx;
   lut_data_t lut_out;

   LookupTable u_lut (
      .instruction (win_idx),
      .out         (lut_out)
   );

   // Grant selection and next-state computation
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      rsp_data_d = rsp_data_q;
      cnt0_d     = cnt0_q;
      cnt1_d     = cnt1_q;

      // Slot frees in the same cycle the owner consumes, giving 1 rsp/cycle
      rsp_hs    = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);
      slot_free = (state_q == IDLE) | rsp_hs;

      grant0  = slot_free & req0_valid & (~req1_valid | ~ptr_q);
      grant1  = slot_free & req1_valid & (~req0_valid |  ptr_q);
      win_idx = grant1 ? req1_idx : req0_idx;

      if (grant0 | grant1) begin
         state_d    = RESP;
         owner_d    = grant1;
         ptr_d      = ~grant1;
         rsp_data_d = lut_out;
         if (grant0 && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
         if (grant1 && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
      end else if (rsp_hs) begin
         state_d = IDLE;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         ptr_q      <= 1'(RESET_PTR);
         rsp_data_q <= 8'h00;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         rsp_data_q <= rsp_data_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state_q == RESP) & ~owner_q;
   assign rsp1_valid = (state_q == RESP) &  owner_q;
   assign rsp0_data  = rsp_data_q;
   assign rsp1_data  = rsp_data_q;
   assign busy       = (state_q == RESP);
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule
